// File: rtl/bg_fill_engine.sv
// Background fill engine: on a start request, writes one WIDTH x HEIGHT frame of a
// single colour through a valid/ready write port, then raises a level-held done.
module bg_fill_engine #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int STRIDE = 1024,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bg_start,
  output logic              bg_start_ack,
  output logic              bg_done,
  input  logic              bg_done_ack,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       fill_color,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);
  // state   | meaning
  // IDLE    | waiting for bg_start while bg_done_ack is low
  // FILL    | issuing pixel writes in raster order
  // DONE_HI | bg_done held high until bg_done_ack is sampled

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DONE_HI = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [23:0]       color_q, color_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      color_q     <= color_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    color_d      = color_q;
    bg_start_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A still-high bg_done_ack means the previous handshake has not returned to zero.
        if (bg_start && !bg_done_ack) begin
          bg_start_ack = 1'b1;
          line_base_d  = base_addr;
          color_d      = fill_color;
          x_d          = '0;
          y_d          = '0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (wr_ready) begin
          if (x_q == X_LAST) begin
            x_d         = '0;
            y_d         = y_q + YW'(1);
            line_base_d = line_base_q + ADDR_W'(STRIDE);
            if (y_q == Y_LAST) begin
              state_d = DONE_HI;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DONE_HI: begin
        if (bg_done_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_valid = (state_q == FILL);
  assign bg_done  = (state_q == DONE_HI);
  assign busy     = (state_q == FILL) || (state_q == DONE_HI);
  assign wr_addr  = line_base_q + ADDR_W'(x_q);
  assign wr_data  = {{(DATA_W-24){1'b0}}, color_q};

endmodule

// File: tb/tb_bg_fill_engine.sv
// Directed bench for bg_fill_engine: a 4x3 instance with stride 8 driven from a frame
// table, plus a 1x1 instance and hand-written handshake and reset sequences.
module tb_bg_fill_engine;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int S  = 8;
  localparam int AW = 27;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, bg_start, bg_done_ack, wr_ready;
  logic [AW-1:0] base_addr;
  logic [23:0]   fill_color;
  logic          bg_start_ack, bg_done, wr_valid, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          u1_start, u1_done_ack;
  logic          u1_start_ack, u1_done, u1_valid, u1_busy;
  logic [AW-1:0] u1_addr;
  logic [DW-1:0] u1_data;

  bg_fill_engine #(.WIDTH(W), .HEIGHT(H), .STRIDE(S), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .bg_start(bg_start), .bg_start_ack(bg_start_ack),
    .bg_done(bg_done), .bg_done_ack(bg_done_ack), .base_addr(base_addr),
    .fill_color(fill_color), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  bg_fill_engine #(.WIDTH(1), .HEIGHT(1), .STRIDE(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clock(clock), .reset_n(reset_n), .bg_start(u1_start), .bg_start_ack(u1_start_ack),
    .bg_done(u1_done), .bg_done_ack(u1_done_ack), .base_addr(base_addr),
    .fill_color(fill_color), .wr_valid(u1_valid), .wr_ready(wr_ready),
    .wr_addr(u1_addr), .wr_data(u1_data), .busy(u1_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor and stall-stability checker.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] stall_a;
  logic [DW-1:0] stall_d;
  int            u1_cnt = 0;

  always @(negedge clock) begin
    if (prev_stall) begin
      check("stall_valid", 64'(wr_valid), 64'(1));
      check("stall_addr", 64'(wr_addr), 64'(stall_a));
      check("stall_data", 64'(wr_data), 64'(stall_d));
    end
    prev_stall = reset_n && wr_valid && !wr_ready;
    stall_a    = wr_addr;
    stall_d    = wr_data;
    if (wr_valid && wr_ready) begin
      qa.push_back(wr_addr);
      qd.push_back(wr_data);
    end
    if (u1_valid && wr_ready) u1_cnt++;
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [23:0]   color;
    int            mode;     // 0: ready=1, 1: ready 1,0,0,1, 2: mid-frame input change
    logic [AW-1:0] first_a;
    logic [AW-1:0] last_a;
  } frame_t;

  frame_t tbl[4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input frame_t f, input bit do_hs);
    logic          prev_acc;
    logic          done_seen;
    logic [AW-1:0] ea;
    logic [3:0]    pat;
    pat       = 4'b1001;
    prev_acc  = 1'b0;
    done_seen = 1'b0;
    qa.delete();
    qd.delete();
    base_addr  = f.base;
    fill_color = f.color;
    bg_start   = 1'b1;
    @(negedge clock);
    check("start_ack", 64'(bg_start_ack), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    tick();
    bg_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      wr_ready = (f.mode == 1) ? pat[c % 4] : 1'b1;
      if (f.mode == 2 && c == 3) begin
        base_addr  = 27'h3000;
        fill_color = 24'h0F0F0F;
        bg_start   = 1'b1;
      end
      if (f.mode == 2 && c == 4) bg_start = 1'b0;
      @(negedge clock);
      if (c == 0) begin
        check("ack_one_cycle", 64'(bg_start_ack), 64'(0));
        check("first_valid", 64'(wr_valid), 64'(1));
        check("fill_busy", 64'(busy), 64'(1));
      end
      if (f.mode == 2 && c == 3) check("start_in_fill_ack", 64'(bg_start_ack), 64'(0));
      if (bg_done) begin
        done_seen = 1'b1;
        check("done_after_last", 64'(prev_acc), 64'(1));
        check("done_valid_low", 64'(wr_valid), 64'(0));
        break;
      end
      prev_acc = wr_valid && wr_ready;
      tick();
    end
    check("done_seen", 64'(done_seen), 64'(1));
    #1;
    check("write_count", 64'(qa.size()), 64'(W * H));
    if (qa.size() == W * H) begin
      check("first_addr", 64'(qa[0]), 64'(f.first_a));
      check("last_addr", 64'(qa[W*H-1]), 64'(f.last_a));
      for (int i = 0; i < W * H; i++) begin
        ea = f.base + AW'((i / W) * S + (i % W));
        check($sformatf("addr[%0d]", i), 64'(qa[i]), 64'(ea));
        check($sformatf("data[%0d]", i), 64'(qd[i]), {40'h0, f.color});
      end
    end
    wr_ready = 1'b1;
    if (do_hs) begin
      tick();
      tick();
      bg_done_ack = 1'b1;
      @(negedge clock);
      check("done_held_until_ack", 64'(bg_done), 64'(1));
      tick();
      @(negedge clock);
      check("done_falls", 64'(bg_done), 64'(0));
      check("idle_after_done", 64'(busy), 64'(0));
      tick();
      bg_done_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base: 27'h100, color: 24'h123456, mode: 0, first_a: 27'h100, last_a: 27'h113};
    tbl[1] = '{base: 27'h100, color: 24'h123456, mode: 1, first_a: 27'h100, last_a: 27'h113};
    tbl[2] = '{base: 27'h200, color: 24'hABCDEF, mode: 2, first_a: 27'h200, last_a: 27'h213};
    tbl[3] = '{base: 27'h7FFFFFE, color: 24'hFFFFFF, mode: 0, first_a: 27'h7FFFFFE, last_a: 27'h011};

    reset_n = 1'b0; bg_start = 1'b0; bg_done_ack = 1'b0; wr_ready = 1'b0;
    base_addr = '0; fill_color = '0; u1_start = 1'b0; u1_done_ack = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_ack", 64'(bg_start_ack), 64'(0));
    check("rst_done", 64'(bg_done), 64'(0));
    check("rst_valid", 64'(wr_valid), 64'(0));
    check("rst_addr", 64'(wr_addr), 64'(0));
    check("rst_data", 64'(wr_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();

    for (int t = 0; t < 4; t++) run_frame(tbl[t], 1'b1);

    // Done handshake with a start request arriving while bg_done_ack is still high.
    run_frame(tbl[0], 1'b0);
    tick();
    tick();
    bg_done_ack = 1'b1;
    bg_start    = 1'b1;
    base_addr   = 27'h100;
    fill_color  = 24'h654321;
    @(negedge clock);
    check("hs_no_ack_in_done", 64'(bg_start_ack), 64'(0));
    tick();
    @(negedge clock);
    check("hs_done_falls", 64'(bg_done), 64'(0));
    check("hs_guard_ack0", 64'(bg_start_ack), 64'(0));
    tick();
    @(negedge clock);
    check("hs_guard_ack1", 64'(bg_start_ack), 64'(0));
    check("hs_guard_busy", 64'(busy), 64'(0));
    tick();
    bg_done_ack = 1'b0;
    @(negedge clock);
    check("hs_ack_after_rtz", 64'(bg_start_ack), 64'(1));

    // Reset after five accepted writes of the frame just started.
    tick();
    bg_start = 1'b0;
    wr_ready = 1'b1;
    qa.delete();
    qd.delete();
    for (int c = 0; c < 50 && qa.size() < 5; c++) begin
      @(negedge clock);
      #1;
    end
    check("rst_mid_reached5", 64'(qa.size()), 64'(5));
    @(posedge clock);
    #1;
    wr_ready = 1'b0;
    reset_n  = 1'b0;
    tick();
    @(negedge clock);
    check("rst_mid_valid", 64'(wr_valid), 64'(0));
    check("rst_mid_done", 64'(bg_done), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_addr", 64'(wr_addr), 64'(0));
    #1;
    check("rst_mid_writes", 64'(qa.size()), 64'(5));
    if (qa.size() == 5) begin
      check("rst_mid_a4", 64'(qa[4]), 64'(27'h108));
      check("rst_mid_d0", 64'(qd[0]), 64'(32'h00654321));
    end
    tick();
    reset_n = 1'b1;
    tick();
    run_frame('{base: 27'h40, color: 24'h55AA55, mode: 0, first_a: 27'h40, last_a: 27'h53}, 1'b1);

    // Single-pixel frame on the 1x1 instance.
    base_addr  = 27'h55;
    fill_color = 24'h00FF00;
    wr_ready   = 1'b1;
    u1_start   = 1'b1;
    @(negedge clock);
    check("u1_ack", 64'(u1_start_ack), 64'(1));
    tick();
    u1_start = 1'b0;
    @(negedge clock);
    check("u1_valid", 64'(u1_valid), 64'(1));
    check("u1_addr", 64'(u1_addr), 64'(27'h55));
    check("u1_data", 64'(u1_data), 64'(32'h0000FF00));
    tick();
    @(negedge clock);
    #1;
    check("u1_done", 64'(u1_done), 64'(1));
    check("u1_valid_low", 64'(u1_valid), 64'(0));
    check("u1_count", 64'(u1_cnt), 64'(1));
    tick();
    u1_done_ack = 1'b1;
    tick();
    @(negedge clock);
    check("u1_done_falls", 64'(u1_done), 64'(0));
    check("u1_busy", 64'(u1_busy), 64'(0));
    tick();
    u1_done_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bg_fill_engine.md
Name: bg_fill_engine

Overview:
- Background-fill stage directly downstream of the swap controller's bg_start / bg_done handshake.
- On each start request it latches the back-buffer base address and fill colour.
- It then writes every pixel of one WIDTH x HEIGHT frame through a valid/ready memory write port.
- When the frame is complete it reports completion with a level-held four-phase done handshake, which the swap controller synchronises and acknowledges.

Parameters:
- WIDTH, 800, pixels per line.
- HEIGHT, 600, lines per frame.
- STRIDE, 1024, address increment between line starts, in words; STRIDE >= WIDTH.
- ADDR_W, 27, memory word-address width.
- DATA_W, 32, write data width; one pixel per word, colour in bits [23:0], bits [DATA_W-1:24] zero.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bg_start  in  1  start request level; held by requester until acknowledged.
- bg_start_ack  out  1  one-cycle acknowledge of bg_start.
- bg_done  out  1  frame-complete level; held until bg_done_ack is seen high.
- bg_done_ack  in  1  done acknowledge level; already synchronised by the requester.
- base_addr  in  ADDR_W  back-buffer base word address; sampled at start.
- fill_color  in  24  RGB fill colour; sampled at start.
- wr_valid  out  1  write request valid.
- wr_ready  in  1  memory accepts the write when wr_valid and wr_ready are both high.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  DATA_W  write data.
- busy  out  1  high in FILL and DONE_HI.

Behaviour:
- Reset: sampled while reset_n = 0 at a clock edge.
  - Outputs: bg_start_ack=0, bg_done=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - Counters x=0, y=0; state IDLE.
  - Reset mid-fill or mid-handshake abandons all progress; no further writes are issued.
- States:
  - IDLE: if bg_start=1 and bg_done_ack=0:
    - pulse bg_start_ack=1 for exactly one cycle;
    - latch base_addr into line_base and fill_color;
    - x=0, y=0; go to FILL.
    - If bg_start=1 while bg_done_ack=1 (previous handshake not yet returned to zero), hold in IDLE with no ack.
  - FILL: wr_valid=1, wr_addr=line_base+x, wr_data={zero pad, colour}.
    - On acceptance (wr_valid & wr_ready):
      - if x = WIDTH-1: x=0, line_base += STRIDE, y += 1;
      - otherwise x += 1.
    - On acceptance when x=WIDTH-1 and y=HEIGHT-1: wr_valid=0 next cycle, bg_done=1, go to DONE_HI.
    - While wr_ready=0: wr_addr and wr_data hold stable and wr_valid stays high (no retraction).
  - DONE_HI: hold bg_done=1 until bg_done_ack=1 is sampled; then bg_done=0, go to IDLE.
    - Return-to-zero of bg_done_ack is enforced by the IDLE start guard.
- Counts and arithmetic:
  - Exactly WIDTH*HEIGHT writes are issued per frame, in raster order.
  - The first address is base; the last address is base + (HEIGHT-1)*STRIDE + WIDTH-1.
  - Address arithmetic is modulo 2^ADDR_W and wraps silently.
  - x is $clog2(WIDTH) bits wide; y is $clog2(HEIGHT) bits wide.
- Start handling during a fill: bg_start asserted in FILL or DONE_HI is ignored (no ack) until the block returns to IDLE.
- Input sampling: base_addr and fill_color changes after the start cycle have no effect on the current frame.
- Throughput and latency:
  - With wr_ready held at 1, the fill sustains one write per cycle.
  - First wr_valid appears the cycle after bg_start_ack.
  - bg_done rises the cycle after the final accepted write.
- Single-cycle frame: WIDTH=1 and HEIGHT=1 must work, issuing one write and then done.

Test Plan:
- Basic frame: WIDTH=4, HEIGHT=3, STRIDE=8, base=0x100, colour=0x123456, wr_ready=1.
  - Expect 12 writes at 0x100-0x103, 0x108-0x10B, 0x110-0x113, all with data 0x00123456.
  - bg_start_ack pulses 1 cycle; bg_done rises 1 cycle after the 12th write.
- Backpressure: same config, wr_ready toggling 1,0,0,1 pattern.
  - Address and data stay stable while stalled; still exactly 12 unique writes in order.
- Done handshake: bg_done_ack returned 2 cycles after bg_done rises.
  - bg_done falls the cycle after the ack is sampled.
  - A new bg_start while bg_done_ack is still 1 gets no ack; ack is issued only once bg_done_ack = 0.
- Input sampling: change base_addr and fill_color mid-frame.
  - All writes use the values latched at start.
  - bg_start pulsed in FILL produces no bg_start_ack.
- Reset mid-fill: assert reset_n=0 after 5 writes.
  - Next cycle: wr_valid=0, bg_done=0, busy=0.
  - A subsequent start refills from base with x=0, y=0.
- Degenerate and wrap cases:
  - WIDTH=1, HEIGHT=1: exactly one write, then done.
  - base=2^ADDR_W-2, WIDTH=4: addresses wrap to 0 and 1.
